alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
- Upstream front-end for the 4-bit ALU / seven-segment display stage.
- Takes raw board switches and two raw pushbuttons. Steps the user through entering operand A, operand B and the opcode.
- Drives the ALU's in_1, in_2, sel and En inputs from registered values, so the displayed result is stable while the switches move.
- Contains a 2-flop synchronizer, a debounce counter per button and a 4-state FSM.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk cycles a synchronized button level must hold before it is accepted; legal range ≥1.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all flops rise-edge triggered.
- rst  input  1  asynchronous, active-high reset.
- sw  input  4  raw data switches: operand value, or opcode in sw[2:0].
- btn_next  input  1  raw pushbutton, active-high; advances the entry sequence.
- btn_clear  input  1  raw pushbutton, active-high; aborts the sequence and clears the operands.
- in_1  output  4  registered operand A to the ALU.
- in_2  output  4  registered operand B to the ALU.
- sel  output  3  registered opcode to the ALU.
- En  output  1  display enable to the ALU stage; high only in S_SHOW.
- phase  output  2  current state encoding for status LEDs: S_A=0, S_B=1, S_OP=2, S_SHOW=3.

Behaviour:
- Reset (async assert, any time including mid-debounce):
  - in_1=0, in_2=0, sel=0, En=0, phase=0 (state S_A).
  - Synchronizer flops, debounced levels, delayed levels and counters all return to 0.
- Reset release: first active edge is the first clk rise after rst deasserts.
- Synchronizer: each button passes through two flops (s1, s2). sw is not synchronized; it is sampled only on a qualifying edge and is assumed static while the button is pressed.
- Debounce, per button, with stable level deb:
  - If s2==deb, the counter clears to 0.
  - Else, if cnt==DEBOUNCE_CYCLES-1, deb<=s2 and the counter clears.
  - Else, cnt<=cnt+1.
- Mismatch runs shorter than DEBOUNCE_CYCLES cycles leave deb unchanged, so glitches are rejected.
- Edge detect: deb_q<=deb every cycle. Press pulse = deb & ~deb_q, one cycle wide. Release produces no pulse.
- Latency: raw rise first sampled at edge 0 gives deb=1 at edge DEBOUNCE_CYCLES+1, and the pulse acts at edge DEBOUNCE_CYCLES+2. For DEBOUNCE_CYCLES=4, the register update occurs at edge 6.
- One pulse per press, regardless of hold time.
- FSM, acting on the edge where a pulse is high:
  - S_A, next pulse: in_1<=sw, go to S_B.
  - S_B, next pulse: in_2<=sw, go to S_OP.
  - S_OP, next pulse: sel<=sw[2:0] (sw[3] ignored), go to S_SHOW.
  - S_SHOW, next pulse: go to S_A. in_1, in_2 and sel are retained, so the old values stay on the ALU inputs until overwritten.
  - Clear pulse in any state: in_1=0, in_2=0, sel=0, go to S_A.
  - Clear and next pulses on the same edge: clear wins and the next pulse is discarded.
  - No pulse: hold state and all registers.
- En is a registered output, equal to (next_state==S_SHOW). It rises on the same edge that sel loads and falls on the edge leaving S_SHOW.
- phase is registered and updates on the same edge as the state.
- Opcodes 3..7 are passed through unchanged; the ALU defines their meaning.
- All outputs are glitch-free flop outputs; no combinational path exists from sw or the buttons to any output.

Test Plan:
(DEBOUNCE_CYCLES=4)
- Async reset: assert rst mid-cycle with btn_next held → all outputs 0 immediately, phase=0. Release rst with the button still high → exactly one pulse after the debounce window, in_1 loaded.
- Full sequence:
  - sw=4'h9, press next → in_1=9, phase=1.
  - sw=4'h3, press → in_2=3, phase=2.
  - sw=4'hA, press → sel=3'b010 (sw[3] dropped), En=1, phase=3.
  - Press again → En=0, phase=0, in_1/in_2/sel still 9/3/2.
- Latency: raw btn_next rises just before edge 0 → in_1 changes exactly at edge 6, not at edge 5.
- Glitch rejection: btn_next high for 3 cycles, then low → no state change. A 5-cycle press → exactly one advance. A press held 100 cycles → exactly one advance.
- Clear: in S_OP with in_1=7, in_2=5, press clear → in_1=in_2=sel=0, phase=0, En=0. Next and clear pressed on the same cycle in S_B → phase=0, in_2 not loaded.
- Bounce: toggle btn_next every 2 cycles for 20 cycles, then hold high → exactly one pulse, measured from the start of the stable-high interval.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry front-end for the 4-bit ALU: synchronizes and debounces two buttons,
// then walks A -> B -> opcode -> show, holding every ALU input in a flop.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] in_1,
    output logic [3:0] in_2,
    output logic [2:0] sel,
    output logic       En,
    output logic [1:0] phase
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_OP   = 2'd2;
    localparam logic [1:0] S_SHOW = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int               NEXT_IDX = 0;
    localparam int               CLR_IDX  = 1;

    logic [1:0]            btn_raw;
    logic [1:0]            s1_q, s2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_dly_q;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic       next_pls, clr_pls;
    logic [1:0] state_q, state_d;
    logic [3:0] in_1_q, in_1_d;
    logic [3:0] in_2_q, in_2_d;
    logic [2:0] sel_q, sel_d;
    logic       en_q, en_d;

    assign btn_raw = {btn_clear, btn_next};

    // A level is accepted only after it has differed from the stable level for a full window.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= btn_raw;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign next_pls = deb_q[NEXT_IDX] & ~deb_dly_q[NEXT_IDX];
    assign clr_pls  = deb_q[CLR_IDX]  & ~deb_dly_q[CLR_IDX];

    // Clear has priority; a coincident next pulse is dropped.
    always_comb begin
        state_d = state_q;
        in_1_d  = in_1_q;
        in_2_d  = in_2_q;
        sel_d   = sel_q;
        if (clr_pls) begin
            state_d = S_A;
            in_1_d  = '0;
            in_2_d  = '0;
            sel_d   = '0;
        end else if (next_pls) begin
            case (state_q)
                S_A: begin
                    in_1_d  = sw;
                    state_d = S_B;
                end
                S_B: begin
                    in_2_d  = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    sel_d   = sw[2:0];
                    state_d = S_SHOW;
                end
                default: state_d = S_A;
            endcase
        end
        en_d = (state_d == S_SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            in_1_q  <= '0;
            in_2_q  <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in_1_q  <= in_1_d;
            in_2_q  <= in_2_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

    assign in_1  = in_1_q;
    assign in_2  = in_2_q;
    assign sel   = sel_q;
    assign En    = en_q;
    assign phase = state_q;

endmodule
